// File: rtl/alu_issue_ctrl.sv
// Command-side issue controller for an external combinational ALU: accepts register
// commands, reads a 4-entry register file, drives the ALU, writes back and returns the result.
module alu_issue_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_ld_i,
  input  logic [2:0]       cmd_op_i,
  input  logic [1:0]       cmd_rd_i,
  input  logic [1:0]       cmd_rs1_i,
  input  logic [1:0]       cmd_rs2_i,
  input  logic             cmd_use_imm_i,
  input  logic [WIDTH-1:0] cmd_imm_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic [1:0]       rsp_rd_o,
  output logic [15:0]      cmd_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_op_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [1:0]       rsp_rd_q;
  logic [15:0]      cmd_cnt_q;
  logic [WIDTH-1:0] regs_q [4];

  logic cmd_fire;
  assign cmd_fire = cmd_valid_i && cmd_ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      cmd_cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            // Operands are sampled here, so rd aliasing rs1/rs2 sees the pre-write value.
            cmd_ready_q <= 1'b0;
            rsp_rd_q    <= cmd_rd_i;
            if (cmd_ld_i) begin
              regs_q[cmd_rd_i] <= cmd_imm_i;
              rsp_data_q       <= cmd_imm_i;
              rsp_valid_q      <= 1'b1;
              state_q          <= RESP;
            end else begin
              alu_op_q <= cmd_op_i;
              alu_a_q  <= regs_q[cmd_rs1_i];
              alu_b_q  <= cmd_use_imm_i ? cmd_imm_i : regs_q[cmd_rs2_i];
              state_q  <= EXEC;
            end
          end
        end
        EXEC: begin
          regs_q[rsp_rd_q] <= alu_res_i;
          rsp_data_q       <= alu_res_i;
          rsp_valid_q      <= 1'b1;
          state_q          <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            cmd_cnt_q   <= cmd_cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign cmd_cnt_o   = cmd_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 8-bit ALU attached to its ALU port.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_ld, cmd_use_imm;
  logic [2:0] cmd_op;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_rd;
  logic [15:0] cmd_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ld_i(cmd_ld), .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd),
    .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
    .cmd_use_imm_i(cmd_use_imm), .cmd_imm_i(cmd_imm),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_res_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_rd_o(rsp_rd), .cmd_cnt_o(cmd_cnt)
  );

  // External combinational ALU: shift amount is the whole operand B.
  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_a - alu_b;
      3'd2: alu_res = alu_a & alu_b;
      3'd3: alu_res = alu_a | alu_b;
      3'd4: alu_res = alu_a ^ alu_b;
      3'd5: alu_res = alu_a >> alu_b;
      default: alu_res = alu_a << alu_b;
    endcase
  end

  typedef struct packed {
    logic       ld;
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       use_imm;
    logic [7:0] imm;
    logic [7:0] exp;
    logic [3:0] hold;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic issue(input vec_t v);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ld = v.ld; cmd_op = v.op; cmd_rd = v.rd;
    cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_use_imm = v.use_imm; cmd_imm = v.imm;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 16'd0, 16'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    if (!v.ld) begin
      check("exec_rsp_valid", 16'(rsp_valid), 16'd0);
      check("exec_alu_op", 16'(alu_op), 16'(v.op));
      @(negedge clk);
    end
    check("rsp_valid", 16'(rsp_valid), 16'd1);
    check("rsp_data", 16'(rsp_data), 16'(v.exp));
    check("rsp_rd", 16'(rsp_rd), 16'(v.rd));
    check("resp_cmd_ready", 16'(cmd_ready), 16'd0);
    for (int k = 0; k < int'(v.hold); k++) begin
      @(negedge clk);
      check("hold_rsp_valid", 16'(rsp_valid), 16'd1);
      check("hold_rsp_data", 16'(rsp_data), 16'(v.exp));
      check("hold_cmd_ready", 16'(cmd_ready), 16'd0);
      check("hold_cmd_cnt", cmd_cnt, exp_cnt);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    check("post_rsp_valid", 16'(rsp_valid), 16'd0);
    check("cmd_cnt", cmd_cnt, exp_cnt);
    $display("txn ld=%0d op=%0d rd=r%0d data=0x%02h cnt=%0d", v.ld, v.op, v.rd, rsp_data, cmd_cnt);
  endtask

  vec_t vecs [17];

  initial begin
    //        ld   op    rd     rs1    rs2    imm?  imm    exp    hold
    vecs[0]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h05, 8'h05, 4'd0};
    vecs[1]  = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h03, 8'h03, 4'd0};
    vecs[2]  = '{1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h08, 4'd0};
    vecs[3]  = '{1'b0, 3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h02, 4'd0};
    vecs[4]  = '{1'b0, 3'd2, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h01, 4'd0};
    vecs[5]  = '{1'b0, 3'd3, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h07, 4'd0};
    vecs[6]  = '{1'b0, 3'd4, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h06, 4'd0};
    vecs[7]  = '{1'b0, 3'd5, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 4'd0};
    vecs[8]  = '{1'b0, 3'd6, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h28, 4'd0};
    vecs[9]  = '{1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFF, 8'hFF, 4'd0};
    vecs[10] = '{1'b0, 3'd0, 2'd0, 2'd0, 2'd3, 1'b1, 8'h02, 8'h01, 4'd0};
    vecs[11] = '{1'b0, 3'd1, 2'd1, 2'd1, 2'd3, 1'b1, 8'h05, 8'hFE, 4'd0};
    vecs[12] = '{1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 8'h03, 8'h03, 4'd0};
    vecs[13] = '{1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h06, 4'd0};
    vecs[14] = '{1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00, 8'h0C, 4'd0};
    vecs[15] = '{1'b0, 3'd7, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01, 8'h18, 4'd0};
    vecs[16] = '{1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 8'hAA, 8'hAA, 4'd5};

    rst = 1'b1; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd0;
    cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_use_imm = 1'b0; cmd_imm = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("rst_rsp_data", 16'(rsp_data), 16'd0);
    check("rst_rsp_rd", 16'(rsp_rd), 16'd0);
    check("rst_alu_a", 16'(alu_a), 16'd0);
    check("rst_alu_b", 16'(alu_b), 16'd0);
    check("rst_alu_op", 16'(alu_op), 16'd0);
    check("rst_cmd_cnt", cmd_cnt, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      issue(vecs[i]);
    end

    // Reset while an add into r2 is executing: no response, r2 cleared, counter cleared.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = 3'd0; cmd_rd = 2'd2;
    cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_use_imm = 1'b0;
    check("pre_rst_cmd_ready", 16'(cmd_ready), 16'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_exec_valid", 16'(rsp_valid), 16'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    check("mid_rst_cmd_ready", 16'(cmd_ready), 16'd0);
    check("mid_rst_cmd_cnt", cmd_cnt, 16'd0);
    rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    check("post_rst_rsp_valid", 16'(rsp_valid), 16'd0);
    issue('{1'b0, 3'd0, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 4'd0});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-side initiator for the team's combinational 8-bit ALU. Accepts register-based commands over a valid/ready handshake, reads operands from a 4-entry register file, drives the ALU operand/opcode inputs, captures the result, writes it back and returns it over a second valid/ready handshake. Sits between a command source (sequencer or testbench) and one external ALU instance.

## Interface
- WIDTH, 8, data width of registers, ALU operands and result
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- cmd_valid_i  input  1  command present
- cmd_ready_o  output  1  command accepted when high with cmd_valid_i
- cmd_ld_i  input  1  1 = load immediate into rd, no ALU use
- cmd_op_i  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shift right, 110/111 shift left
- cmd_rd_i  input  2  destination register
- cmd_rs1_i  input  2  operand A register
- cmd_rs2_i  input  2  operand B register
- cmd_use_imm_i  input  1  1 = operand B taken from cmd_imm_i instead of rs2
- cmd_imm_i  input  WIDTH  immediate
- alu_a_o  output  WIDTH  to ALU operand A
- alu_b_o  output  WIDTH  to ALU operand B
- alu_op_o  output  3  to ALU opcode
- alu_res_i  input  WIDTH  from ALU result (combinational from alu_*_o)
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  response consumed when high with rsp_valid_o
- rsp_data_o  output  WIDTH  value written to rd
- rsp_rd_o  output  2  register written
- cmd_cnt_o  output  16  completed-command counter

## Operation
- States: IDLE, EXEC, RESP. Reset -> IDLE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch rd; latch op into alu_op_o; latch reg[rs1] into alu_a_o; latch (use_imm ? imm : reg[rs2]) into alu_b_o. If cmd_ld_i: write imm to reg[rd], load rsp_data_o=imm, go RESP (alu_* registers unchanged). Else go EXEC.
- EXEC (exactly 1 cycle): alu_* outputs stable; at cycle end write alu_res_i to reg[rd], load rsp_data_o=alu_res_i, go RESP.
- RESP: rsp_valid_o=1, rsp_data_o/rsp_rd_o held stable. On rsp_ready_i: cmd_cnt_o+1, go IDLE.
- cmd_ready_o low in EXEC and RESP; rsp_valid_o low in IDLE and EXEC.
- Operands sampled at accept: rd equal to rs1/rs2 uses pre-write value.
- Arithmetic performed by the external ALU; result truncated to WIDTH, no carry/flags. Shift amount is full alu_b_o.
- Block never modifies the opcode; 110 and 111 both pass through.
- cmd_cnt_o wraps 0xFFFF -> 0x0000.

## Timing
- Reset values: cmd_ready_o=0 during reset cycle then 1 in IDLE; rsp_valid_o=0, rsp_data_o=0, rsp_rd_o=0, alu_a_o=0, alu_b_o=0, alu_op_o=0, cmd_cnt_o=0, all registers 0.
- ALU command accepted at edge N -> EXEC during cycle N+1 -> rsp_valid_o high from cycle N+2.
- Load command accepted at edge N -> rsp_valid_o high from cycle N+1.
- Register write visible to a command accepted at least one cycle after rsp handshake (always true: accept only in IDLE).
- Minimum throughput: ALU command every 3 cycles, load every 2, with rsp_ready_i tied high.
- Backpressure: rsp_ready_i low holds RESP indefinitely, no further commands accepted.
- cmd_valid_i while cmd_ready_o low is ignored; source must hold it.
- Reset in any state: immediate return to IDLE, in-flight response dropped, no write, counter and registers cleared.

## Test plan
- Reset then loads: ld r0=0x05, ld r1=0x03 -> responses (r0,0x05),(r1,0x03), each valid 1 cycle after accept, cmd_cnt_o=2.
- ALU ops r2=r0 op r1 for op 000..110 -> rsp_data_o 0x08,0x02,0x01,0x07,0x06,0x00,0x28; alu_op_o equals cmd_op_i during EXEC.
- Wrap and immediate: ld r0=0xFF; add r0=r0+imm 0x02 -> 0x01; sub r1=r1(0x03)-imm 0x05 -> 0xFE.
- Backpressure: hold rsp_ready_i low 5 cycles -> rsp_valid_o and data stable, cmd_ready_o low, counter unchanged until handshake.
- Hazard: rd=rs1=rs2=r1 (0x03), add -> 0x06; following add r1 -> 0x0C.
- Reset during EXEC after `add r2` accepted -> no response, r2 reads 0 (verify via ld-free add r3=r2+imm 0 -> 0x00), cmd_cnt_o=0.
